// File: rtl/fetch_stage.sv
// Fetch stage and F/D pipeline register: owns PCF, drives a req/valid instruction
// memory, and feeds Decode with instructions or bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic [31:0] ImemRdata,
    input  logic        ImemValid,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus8;
        logic            valid;
    } fd_t;

    localparam fd_t FD_BUBBLE = '{instr: BUBBLE_INSTR, pc_plus8: '0, valid: 1'b0};

    state_t          state_q, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] req_addr_q, req_addr_nxt;
    logic [XLEN-1:0] hold_q, hold_nxt;
    fd_t             fd_q, fd_nxt;

    logic            redirect;
    logic            advance;
    logic [XLEN-1:0] target;
    logic            deliver;
    logic [XLEN-1:0] deliver_instr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_q     <= '0;
            fd_q       <= FD_BUBBLE;
        end else begin
            state_q    <= state_nxt;
            pc_q       <= pc_nxt;
            req_addr_q <= req_addr_nxt;
            hold_q     <= hold_nxt;
            fd_q       <= fd_nxt;
        end
    end

    // Fetch control and F/D next-state
    always_comb begin
        redirect      = BranchTakenE | PCSrcW;
        target        = BranchTakenE ? ALUResultE : ResultW;
        advance       = !StallF && !StallD && !redirect;

        state_nxt     = state_q;
        pc_nxt        = pc_q;
        req_addr_nxt  = req_addr_q;
        hold_nxt      = hold_q;
        deliver       = 1'b0;
        deliver_instr = hold_q;
        fd_nxt        = fd_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_nxt = target;
                    if (ImemValid) begin
                        req_addr_nxt = target;
                    end else begin
                        state_nxt = S_DISCARD;
                    end
                end else if (ImemValid) begin
                    if (advance) begin
                        deliver       = 1'b1;
                        deliver_instr = ImemRdata;
                        pc_nxt        = pc_q + XLEN'(4);
                        req_addr_nxt  = pc_q + XLEN'(4);
                    end else begin
                        hold_nxt  = ImemRdata;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (advance) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_q;
                    pc_nxt        = pc_q + XLEN'(4);
                    req_addr_nxt  = pc_q + XLEN'(4);
                    state_nxt     = S_FETCH;
                end else if (redirect) begin
                    hold_nxt     = '0;
                    pc_nxt       = target;
                    req_addr_nxt = target;
                    state_nxt    = S_FETCH;
                end
            end
            S_DISCARD: begin
                // The stale request stays on the bus until memory answers it.
                if (redirect) begin
                    pc_nxt = target;
                end
                if (ImemValid) begin
                    req_addr_nxt = pc_nxt;
                    state_nxt    = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        if (FlushD) begin
            fd_nxt = FD_BUBBLE;
        end else if (StallD) begin
            fd_nxt = fd_q;
        end else if (deliver) begin
            fd_nxt.instr    = deliver_instr;
            fd_nxt.pc_plus8 = pc_q + XLEN'(8);
            fd_nxt.valid    = 1'b1;
        end else begin
            fd_nxt = FD_BUBBLE;
        end
    end

    assign ImemReq    = (state_q != S_HOLD);
    assign ImemAddr   = req_addr_q;
    assign PCF        = pc_q;
    assign InstrD     = fd_q.instr;
    assign PCPlus8D   = fd_q.pc_plus8;
    assign ValidD     = fd_q.valid;
    assign FetchBusyF = !((state_q == S_HOLD) || ((state_q == S_FETCH) && ImemValid));

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus random stalls, redirects and
// memory latency, checked against a program-order scoreboard of expected PCs.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] BUBBLE   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD;
    logic        BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic        ImemValid;
    logic [31:0] PCF, InstrD, PCPlus8D;
    logic        ValidD, FetchBusyF;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          lat_mode = 0;     // <0: random latency 0..3 wait cycles
    logic [31:0] exp_q[$];
    logic [31:0] model_next;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC), .BUBBLE_INSTR(BUBBLE)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW),
        .ResultW(ResultW), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemRdata(ImemRdata), .ImemValid(ImemValid), .PCF(PCF), .InstrD(InstrD),
        .PCPlus8D(PCPlus8D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 2) begin
            exp_q.push_back(model_next);
            model_next = model_next + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        topup();
    endtask

    // Apply one cycle's hazard/redirect inputs; a redirect restarts program order.
    task automatic drive(input logic sf, input logic sd, input logic fd, input logic bt,
                         input logic [31:0] alu, input logic pw, input logic [31:0] rw);
        logic [31:0] tgt;
        StallF = sf; StallD = sd; FlushD = fd;
        BranchTakenE = bt; ALUResultE = alu; PCSrcW = pw; ResultW = rw;
        if (bt || pw) begin
            tgt = bt ? alu : rw;
            exp_q.delete();
            exp_q.push_back(tgt);
            model_next = tgt + 32'd4;
        end
        topup();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'($urandom), 1'b0, 32'($urandom));
    endtask

    task automatic release_reset();
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        model_next = RESET_PC + 32'd4;
    endtask

    // Instruction memory with per-request latency
    initial begin
        bit          busy;
        int          wait_left;
        logic [31:0] seen;
        busy = 1'b0; wait_left = 0; seen = '0;
        ImemValid = 1'b0; ImemRdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0;
                ImemValid = 1'b0;
            end else if (ImemReq) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    seen = ImemAddr;
                end else begin
                    check("imem_addr_stable", ImemAddr, seen);
                end
                if (wait_left == 0) begin
                    ImemValid = 1'b1;
                    ImemRdata = mem_word(ImemAddr);
                    busy = 1'b0;
                end else begin
                    wait_left--;
                    ImemValid = 1'b0;
                    ImemRdata = 32'($urandom);
                end
            end else begin
                ImemValid = 1'b0;
                ImemRdata = 32'($urandom);
            end
        end
    end

    // Monitor: every F/D update is a bubble, a hold, or the next program-order instruction
    initial begin
        logic [31:0] p_instr, p_pc8, epc;
        logic        p_valid;
        p_instr = BUBBLE; p_pc8 = '0; p_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (FlushD) begin
                    check("flush_valid", 32'(ValidD), 32'd0);
                    check("flush_instr", InstrD, BUBBLE);
                    check("flush_pc8", PCPlus8D, 32'd0);
                end else if (StallD) begin
                    check("stalld_instr", InstrD, p_instr);
                    check("stalld_pc8", PCPlus8D, p_pc8);
                    check("stalld_valid", 32'(ValidD), 32'(p_valid));
                end else if (ValidD) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_instr: got pc8 %h expected none", PCPlus8D);
                    end else begin
                        epc = exp_q.pop_front();
                        check("deliver_pc8", PCPlus8D, epc + 32'd8);
                        check("deliver_instr", InstrD, mem_word(epc));
                    end
                end else begin
                    check("bubble_instr", InstrD, BUBBLE);
                    check("bubble_pc8", PCPlus8D, 32'd0);
                end
            end
            p_instr = InstrD; p_pc8 = PCPlus8D; p_valid = ValidD;
        end
    end

    // Stimulus
    initial begin
        logic        sf, sd, bt, pw;
        logic [31:0] alu, rw;
        int          r;
        reset = 1'b1;
        lat_mode = 0;
        model_next = RESET_PC + 32'd4;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        check("rst_pcf", PCF, RESET_PC);
        check("rst_addr", ImemAddr, RESET_PC);
        check("rst_req", 32'(ImemReq), 32'd1);
        check("rst_instr", InstrD, BUBBLE);
        check("rst_pc8", PCPlus8D, 32'd0);
        check("rst_valid", 32'(ValidD), 32'd0);

        // zero-latency streaming
        release_reset();
        idle();
        tick();
        check("z_pcf1", PCF, 32'd4);
        check("z_instr0", InstrD, mem_word(32'd0));
        check("z_pc8", PCPlus8D, 32'd8);
        check("z_valid", 32'(ValidD), 32'd1);
        tick();
        check("z_pcf2", PCF, 32'd8);
        tick();
        check("z_pcf3", PCF, 32'd12);

        // two-cycle memory
        lat_mode = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("l2_busy_wait", 32'(FetchBusyF), 32'd1);
            tick();
            check("l2_gap_valid", 32'(ValidD), 32'd0);
            @(negedge clk); #1;
            check("l2_busy_hit", 32'(FetchBusyF), 32'd0);
            tick();
            check("l2_valid", 32'(ValidD), 32'd1);
            check("l2_instr", InstrD, mem_word(32'd12 + 32'(4 * k)));
        end

        // stall while a response arrives
        lat_mode = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_req", 32'(ImemReq), 32'd0);
            check("hold_busy", 32'(FetchBusyF), 32'd0);
            check("hold_instr", InstrD, mem_word(32'd20));
            check("hold_pcf", PCF, 32'd24);
        end
        idle();
        tick();
        check("rel_instr", InstrD, mem_word(32'd24));
        check("rel_pcf", PCF, 32'd28);
        tick();
        check("rel_next", InstrD, mem_word(32'd28));
        check("rel_pcf2", PCF, 32'd32);

        // branch while a slow request is outstanding
        lat_mode = 2;
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'($urandom));
        tick();
        check("br_pcf", PCF, 32'h100);
        check("br_old_addr", ImemAddr, 32'd32);
        idle();
        tick();
        check("br_new_addr", ImemAddr, 32'h100);
        check("br_drop", 32'(ValidD), 32'd0);
        lat_mode = 0;
        tick();
        check("br_instr", InstrD, mem_word(32'h100));
        check("br_pc8", PCPlus8D, 32'h108);
        check("br_pcf2", PCF, 32'h104);

        // simultaneous redirects: Execute wins
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80);
        tick();
        check("both_pcf", PCF, 32'h40);
        check("both_addr", ImemAddr, 32'h40);
        idle();
        tick();
        check("both_instr", InstrD, mem_word(32'h40));
        check("both_pcf2", PCF, 32'h44);

        // PC wrap
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'($urandom), 1'b1, 32'hFFFF_FFFC);
        tick();
        check("wrap_pcf", PCF, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap_instr", InstrD, mem_word(32'hFFFF_FFFC));
        check("wrap_pc8", PCPlus8D, 32'h0000_0004);
        check("wrap_pcf2", PCF, 32'd0);

        // flush beats stall
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        check("fs_valid", 32'(ValidD), 32'd0);
        check("fs_req", 32'(ImemReq), 32'd0);
        idle();
        tick();
        check("fs_instr", InstrD, mem_word(32'd0));
        check("fs_pcf", PCF, 32'd4);

        // async reset in the middle of a discard
        lat_mode = 3;
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'd0);
        tick();
        check("dis_pcf", PCF, 32'h200);
        check("dis_addr", ImemAddr, 32'd4);
        check("dis_busy", 32'(FetchBusyF), 32'd1);
        idle();
        #1;
        reset = 1'b1;
        #1;
        check("arst_pcf", PCF, RESET_PC);
        check("arst_addr", ImemAddr, RESET_PC);
        check("arst_req", 32'(ImemReq), 32'd1);
        check("arst_instr", InstrD, BUBBLE);
        check("arst_pc8", PCPlus8D, 32'd0);
        check("arst_valid", 32'(ValidD), 32'd0);
        tick();
        tick();
        release_reset();
        idle();
        lat_mode = -1;

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r  = int'($urandom_range(0, 99));
            sf = (r < 20) || (r >= 25 && r < 30);
            sd = (r < 25);
            r  = int'($urandom_range(0, 99));
            bt = (r < 6);
            pw = (r >= 4 && r < 10);
            alu = 32'($urandom);
            rw  = 32'($urandom);
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rw[1:0]  = 2'b00;
            drive(sf, sd, bt | pw, bt, alu, pw, rw);
            tick();
        end

        idle();
        repeat (6) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
